// File: rtl/cpu_bus_responder_pkg.sv
// Shared constants for the Taito F2 CPU bus: decoded region indices and the
// bus responder state encoding.
package system_consts;

  localparam int REGION_IDX_W = 4;

  localparam int ROM       = 0;
  localparam int WORK      = 1;
  localparam int SCREEN    = 2;
  localparam int OBJECT    = 3;
  localparam int COLOR     = 4;
  localparam int IO0       = 5;
  localparam int IO1       = 6;
  localparam int SOUND     = 7;
  localparam int EXTENSION = 8;
  localparam int PRIORITY  = 9;
  localparam int CCHIP     = 10;
  localparam int PIVOT     = 11;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_PEND = 2'd1,
    BR_WAIT = 2'd2,
    BR_ACK  = 2'd3
  } bus_resp_state_t;

endpackage

// File: rtl/cpu_bus_responder_prio_enc.sv
// Combinational priority encoder over active-low region selects; index 0 wins,
// flags "none active" and "more than one active".
module region_priority_enc
  import system_consts::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]            region_n,
  output logic [REGION_IDX_W-1:0] index,
  output logic                    none,
  output logic                    multi
);

  logic [N-1:0] sel;

  always_comb begin
    sel   = ~region_n;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) index = REGION_IDX_W'(i);
    end
    none  = ~|sel;
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi = |(sel & (sel - N'(1)));
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// Terminates every 68000 bus cycle with DTACKn after a per-region wait or an
// arbiter ready, or with BERRn on timeout; acknowledges hold until AS# negates.
module cpu_bus_responder
  import system_consts::*;
#(
  parameter int REGION_COUNT   = 16,
  parameter int UNMAPPED_WAIT  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_as_n,
  input  logic [1:0]                cpu_ds_n,
  input  logic [REGION_COUNT-1:0]   region_n,
  input  logic [REGION_COUNT-1:0]   region_ext,
  input  logic [4*REGION_COUNT-1:0] region_wait,
  input  logic                      ext_ready,
  output logic                      ext_req,
  output logic [3:0]                ext_region,
  output logic                      cpu_dtack_n,
  output logic                      cpu_berr_n,
  output logic                      busy,
  output logic                      overlap_err,
  output logic [7:0]                timeout_count
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;

  bus_resp_state_t   state_q;
  logic              pending_q, ext_q, ext_req_q, dtack_n_q, berr_n_q, busy_q, overlap_q;
  logic [3:0]        idx_q, ext_region_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        tcount_q, tcount_d;

  logic [3:0] enc_idx, sel_wait;
  logic       enc_none, enc_multi, start, sel_ext, timeout_hit;

  region_priority_enc #(.N(REGION_COUNT)) u_enc (
    .region_n (region_n),
    .index    (enc_idx),
    .none     (enc_none),
    .multi    (enc_multi)
  );

  assign start       = ~cpu_as_n & ~(&cpu_ds_n);
  assign sel_ext     = ~enc_none & region_ext[enc_idx];
  assign sel_wait    = region_wait[int'(enc_idx)*4 +: 4];
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign tcount_d    = (tcount_q == 8'hFF) ? tcount_q : tcount_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BR_IDLE;
      pending_q    <= 1'b0;
      ext_q        <= 1'b0;
      ext_req_q    <= 1'b0;
      ext_region_q <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      dtack_n_q    <= 1'b1;
      berr_n_q     <= 1'b1;
      busy_q       <= 1'b0;
      overlap_q    <= 1'b0;
      tcount_q     <= '0;
    end else begin
      ext_req_q <= 1'b0;
      case (state_q)
        BR_IDLE: begin
          if (ext_ready) pending_q <= 1'b0;
          if (start) begin
            idx_q  <= enc_idx;
            ext_q  <= sel_ext;
            busy_q <= 1'b1;
            if (enc_multi) overlap_q <= 1'b1;
            if (!sel_ext) begin
              cnt_q   <= enc_none ? CNT_W'(UNMAPPED_WAIT) : CNT_W'(sel_wait);
              state_q <= BR_WAIT;
            end else begin
              cnt_q <= '0;
              // A ready on this same edge retires the stale request first.
              if (pending_q && !ext_ready) begin
                state_q <= BR_PEND;
              end else begin
                ext_req_q    <= 1'b1;
                ext_region_q <= enc_idx;
                pending_q    <= 1'b1;
                state_q      <= BR_WAIT;
              end
            end
          end
        end
        BR_PEND: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (ext_ready) pending_q <= 1'b0;
          if (cpu_as_n) begin
            state_q <= BR_IDLE;
            busy_q  <= 1'b0;
          end else if (timeout_hit) begin
            berr_n_q <= 1'b0;
            tcount_q <= tcount_d;
            state_q  <= BR_ACK;
          end else if (!pending_q) begin
            ext_req_q    <= 1'b1;
            ext_region_q <= idx_q;
            pending_q    <= 1'b1;
            state_q      <= BR_WAIT;
          end
        end
        BR_WAIT: begin
          if (cpu_as_n) begin
            if (ext_q && ext_ready) pending_q <= 1'b0;
            state_q <= BR_IDLE;
            busy_q  <= 1'b0;
          end else if (!ext_q) begin
            if (cnt_q == '0) begin
              dtack_n_q <= 1'b0;
              state_q   <= BR_ACK;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end else if (ext_ready) begin
            dtack_n_q <= 1'b0;
            pending_q <= 1'b0;
            state_q   <= BR_ACK;
          end else if (timeout_hit) begin
            berr_n_q <= 1'b0;
            tcount_q <= tcount_d;
            state_q  <= BR_ACK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        BR_ACK: begin
          // A late ready for a timed-out request would otherwise never be retired.
          if (ext_ready) pending_q <= 1'b0;
          if (cpu_as_n) begin
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= BR_IDLE;
          end
        end
        default: state_q <= BR_IDLE;
      endcase
    end
  end

  assign ext_req       = ext_req_q;
  assign ext_region    = ext_region_q;
  assign cpu_dtack_n   = dtack_n_q;
  assign cpu_berr_n    = berr_n_q;
  assign busy          = busy_q;
  assign overlap_err   = overlap_q;
  assign timeout_count = tcount_q;

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Completes every 68000 bus cycle in the Taito F2 core. It sits behind the CPU address decoder and takes that decoder's active-low region selects. Each cycle finishes in one of three ways: after a fixed per-region wait, on an external ready from the SDRAM/ROM arbiter, or with a bus error on timeout. Its outputs are DTACKn/BERRn to the CPU, and it enforces the 68000 rule that acknowledges are held until AS# negates.

## Interface
Parameters:
- REGION_COUNT, 16, number of decoded select lines; index 0 has highest priority
- UNMAPPED_WAIT, 2, wait in clk cycles when no select is active
- TIMEOUT_CYCLES, 255, clk edges in WAIT before an external-ready region is failed

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- cpu_as_n  in  1  CPU address strobe
- cpu_ds_n  in  2  CPU upper/lower data strobes
- region_n  in  REGION_COUNT  decoded selects, active low, stable while cpu_as_n low
- region_ext  in  REGION_COUNT  1 = region completes on ext_ready; 0 = fixed wait
- region_wait  in  4*REGION_COUNT  fixed wait per region, region_wait[4i+3:4i], 0..15
- ext_ready  in  1  one-cycle completion pulse from arbiter
- ext_req  out  1  one-cycle request pulse to arbiter
- ext_region  out  4  index of region being requested, valid with ext_req
- cpu_dtack_n  out  1  data acknowledge
- cpu_berr_n  out  1  bus error
- busy  out  1  high in any state other than IDLE
- overlap_err  out  1  sticky: more than one select was active at a start
- timeout_count  out  8  saturating count of timed-out cycles

## Operation
- Outputs are all registered. Reset values:
  - cpu_dtack_n=1, cpu_berr_n=1
  - ext_req=0, ext_region=0
  - busy=0, overlap_err=0, timeout_count=0
  - state IDLE, pending=0
- Start condition: in IDLE, cpu_as_n=0 and ~&cpu_ds_n. At that edge (E0):
  - latch the lowest active region index; if no select is active, mark the cycle unmapped;
  - if two or more selects are active, set overlap_err=1;
  - clear the wait/timeout counter.
- Fixed region (region_ext[i]=0), or unmapped: load W = region_wait[i] (UNMAPPED_WAIT if unmapped) and go to WAIT.
- External region, pending=0: issue ext_req=1 and ext_region=i for one cycle, set pending=1, go to WAIT.
- External region, pending=1: go to PEND.
  - PEND waits for ext_ready from a stale request; that pulse is consumed, not used to complete this cycle.
  - When it arrives, clear pending, then issue ext_req on the next edge and go to WAIT.
- WAIT, fixed region: at each edge, if the count is 0, set cpu_dtack_n=0 and go to ACK; otherwise decrement.
- WAIT, external region: on the edge where ext_ready=1, set cpu_dtack_n=0, clear pending, go to ACK.
- Timeout: the counter runs in PEND and WAIT for external regions.
  - When it reaches TIMEOUT_CYCLES: set cpu_berr_n=0, leave cpu_dtack_n=1, increment timeout_count (saturating at 255), go to ACK.
  - pending stays set.
- ACK: hold the outputs until cpu_as_n=1 is sampled. At that edge, set cpu_dtack_n=1 and cpu_berr_n=1 and go to IDLE.
- Abort: if cpu_as_n=1 is sampled in PEND or WAIT, go to IDLE with no acknowledge.
  - An outstanding request leaves pending=1.
  - A later ext_ready is then consumed as stale, in IDLE or in PEND.
- In IDLE, ext_ready with pending=1 clears pending. ext_ready with pending=0 is ignored.
- ext_ready arriving on the same edge as a start is applied to pending first, so that start sees pending=0.
- States: IDLE, PEND, WAIT, ACK.

## Timing
- Fixed wait W: cpu_dtack_n is low after edge E(W+1). W=0 gives DTACK one clk after the start edge.
- External region:
  - ext_req is high for exactly the one cycle after E0.
  - The earliest ext_ready that is sampled is at E1.
  - cpu_dtack_n falls after the edge that samples ext_ready.
- Release: DTACKn and BERRn rise one edge after cpu_as_n=1 is sampled. A new start is accepted at the earliest on the edge after that.
- Timeout: BERRn falls after edge E(TIMEOUT_CYCLES), counted from E0.
- reset mid-cycle: all outputs take their reset values immediately (asynchronous), and the in-flight ext request is forgotten.

## Structure
- Add the following to the existing system_consts package:
  - region index constants (ROM=0, WORK, SCREEN, OBJECT, COLOR, IO0, IO1, SOUND, EXTENSION, PRIORITY, CCHIP, PIVOT);
  - the bus_resp_state_t enum.
- One sub-module, region_priority_enc: combinational. Takes region_n and produces index, none, and multi.

## Test plan
- region_n=16'hFFFE, region_wait[3:0]=3, AS/DS low at E0 -> DTACKn low after E4. It stays low until AS high, then rises one edge later.
- Region 0 with region_ext[0]=1, ext_ready pulsed 5 cycles after ext_req -> ext_req one cycle with ext_region=0. DTACKn low after the ready edge; pending=0 afterwards.
- External region with no ext_ready, TIMEOUT_CYCLES=16 -> BERRn low after E16, DTACKn stays 1, timeout_count=1. Repeat 300 times -> timeout_count=255.
- Abort WAIT by raising AS, then start a new external cycle before the stale ready -> PEND, no ext_req until the stale ready. Then exactly one new ext_req, and DTACK only on the second ready.
- region_n=16'hFFFA (regions 0 and 2 active) -> region 0's wait is used, overlap_err=1 until reset. All ones -> DTACK after UNMAPPED_WAIT+1 edges.
- Assert reset while in ACK with DTACKn=0 -> DTACKn=1, busy=0, timeout_count=0 in the same cycle, with no clock edge required.
